// File: rtl/or_unit_initiator_if.sv
`default_nettype none
// ============================================================================
// Module      : or_unit_initiator_if
// Description : Command, response and register-bus signals of the OR unit
//               initiator.
// Revision    : 1.0 - initial release
// ============================================================================
interface or_unit_initiator_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_err;
  logic [2:0] write_address;
  logic [7:0] write_data;
  logic       write_en;
  logic       write_rdy;
  logic [2:0] read_address;
  logic       read_en;
  logic [7:0] read_data;
  logic       read_rdy;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, res_ready, write_rdy, read_data, read_rdy,
    output cmd_ready, res_valid, res_data, res_err,
           write_address, write_data, write_en, read_address, read_en
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, res_ready, write_rdy, read_data, read_rdy,
    input  cmd_ready, res_valid, res_data, res_err,
           write_address, write_data, write_en, read_address, read_en
  );
endinterface
`default_nettype wire

// File: rtl/or_unit_initiator.sv
`default_nettype none
// ============================================================================
// Module      : or_unit_initiator
// Description : Drives one OR unit over its register bus: polls, writes A/B,
//               polls for and dequeues the result, returns it on res_*.
// Revision    : 1.0 - initial release
// ============================================================================
module or_unit_initiator #(
  parameter int POLL_LIMIT = 1023,
  parameter int POLL_W     = 10
) (
  input  wire logic           CLK,
  input  wire logic           RST,
  or_unit_initiator_if.master bus
);
  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_POLL_A = 3'd1;
  localparam logic [2:0] c_WR_A   = 3'd2;
  localparam logic [2:0] c_POLL_B = 3'd3;
  localparam logic [2:0] c_WR_B   = 3'd4;
  localparam logic [2:0] c_POLL_Y = 3'd5;
  localparam logic [2:0] c_RD_Y   = 3'd6;
  localparam logic [2:0] c_RESP   = 3'd7;

  localparam logic [POLL_W-1:0] c_POLL_LAST = POLL_W'(POLL_LIMIT - 1);

  logic [2:0]        r_state;
  logic [7:0]        r_a;
  logic [7:0]        r_b;
  logic [7:0]        r_res;
  logic              r_err;
  logic [POLL_W-1:0] r_poll_cnt;

  logic              w_cmd_ready;
  logic              w_res_valid;
  logic              w_write_en;
  logic [2:0]        w_write_address;
  logic [7:0]        w_write_data;
  logic              w_read_en;
  logic [2:0]        w_read_address;
  logic [2:0]        w_poll_pass;

  // Outputs depend on the state register only.
  always_comb begin
    w_cmd_ready     = 1'b0;
    w_res_valid     = 1'b0;
    w_write_en      = 1'b0;
    w_write_address = 3'd0;
    w_write_data    = 8'h00;
    w_read_en       = 1'b0;
    w_read_address  = 3'd0;
    w_poll_pass     = c_IDLE;
    case (r_state)
      c_IDLE:   w_cmd_ready = 1'b1;
      c_POLL_A: begin w_read_en = 1'b1; w_read_address = 3'd0; w_poll_pass = c_WR_A; end
      c_WR_A:   begin w_write_en = 1'b1; w_write_address = 3'd4; w_write_data = r_a; end
      c_POLL_B: begin w_read_en = 1'b1; w_read_address = 3'd1; w_poll_pass = c_WR_B; end
      c_WR_B:   begin w_write_en = 1'b1; w_write_address = 3'd5; w_write_data = r_b; end
      c_POLL_Y: begin w_read_en = 1'b1; w_read_address = 3'd2; w_poll_pass = c_RD_Y; end
      c_RD_Y:   begin w_read_en = 1'b1; w_read_address = 3'd3; end
      c_RESP:   w_res_valid = 1'b1;
      default:  w_cmd_ready = 1'b0;
    endcase
  end

  // Reset forces every output low immediately, not just after the next edge.
  assign bus.cmd_ready     = w_cmd_ready & ~RST;
  assign bus.res_valid     = w_res_valid & ~RST;
  assign bus.res_data      = RST ? 8'h00 : r_res;
  assign bus.res_err       = r_err & ~RST;
  assign bus.write_en      = w_write_en & ~RST;
  assign bus.write_address = RST ? 3'd0 : w_write_address;
  assign bus.write_data    = RST ? 8'h00 : w_write_data;
  assign bus.read_en       = w_read_en & ~RST;
  assign bus.read_address  = RST ? 3'd0 : w_read_address;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= c_IDLE;
      r_a        <= 8'h00;
      r_b        <= 8'h00;
      r_res      <= 8'h00;
      r_err      <= 1'b0;
      r_poll_cnt <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (bus.cmd_valid) begin
            r_a     <= bus.cmd_a;
            r_b     <= bus.cmd_b;
            r_state <= c_POLL_A;
          end
        end
        c_POLL_A, c_POLL_B, c_POLL_Y: begin
          if (bus.read_rdy) begin
            if (bus.read_data[0]) begin
              r_state    <= w_poll_pass;
              r_poll_cnt <= '0;
            end else if (r_poll_cnt == c_POLL_LAST) begin
              r_state    <= c_RESP;
              r_res      <= 8'h00;
              r_err      <= 1'b1;
              r_poll_cnt <= '0;
            end else begin
              r_poll_cnt <= r_poll_cnt + 1'b1;
            end
          end
        end
        c_WR_A: if (bus.write_rdy) r_state <= c_POLL_B;
        c_WR_B: if (bus.write_rdy) r_state <= c_POLL_Y;
        c_RD_Y: begin
          if (bus.read_rdy) begin
            r_res   <= bus.read_data;
            r_err   <= 1'b0;
            r_state <= c_RESP;
          end
        end
        c_RESP:  if (bus.res_ready) r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_or_unit_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_or_unit_initiator
// Description : Randomized bench with an OR-unit bus model and a per-command
//               expectation derived from the scripted status responses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_or_unit_initiator;
  localparam int LIM = 8;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  or_unit_initiator_if bus ();

  or_unit_initiator #(.POLL_LIMIT(LIM), .POLL_W(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] seq [3][$];
  int         ptr [3];
  int         pend_rd;
  int         nrd [8];
  int         nwr_a, nwr_b;
  logic [7:0] wa, wb;
  logic [7:0] cur_a, cur_b, exp_res;
  logic       exp_err;
  int         exp_rd [4];
  int         exp_wa, exp_wb;
  bit         fast, want_cmd, rst_drive;
  int         hold_w, hold_r, n_wstall, n_rstall;
  int         cyc, acc_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] status_of(input logic [2:0] ad);
    if (ad < 3'd3) return (ptr[ad] < seq[ad].size()) ? seq[ad][ptr[ad]] : 8'h01;
    if (ad == 3'd3) return wa | wb;
    return 8'h00;
  endfunction

  function automatic int not_ready_count(input int p);
    for (int i = 0; i < seq[p].size(); i++)
      if (seq[p][i][0]) return i;
    return seq[p].size();
  endfunction

  task automatic fill(input int p, input int n);
    logic [7:0] v;
    seq[p].delete();
    repeat (n) begin v = 8'($urandom); v[0] = 1'b0; seq[p].push_back(v); end
    v = 8'($urandom); v[0] = 1'b1; seq[p].push_back(v);
  endtask

  task automatic push_n(input int p, input logic [7:0] v, input int n);
    repeat (n) seq[p].push_back(v);
  endtask

  task automatic step();
    @(negedge CLK);
    if (pend_rd >= 0 && pend_rd <= 2) ptr[pend_rd]++;
    pend_rd        = -1;
    RST            = rst_drive;
    bus.cmd_valid  = want_cmd;
    bus.cmd_a      = want_cmd ? cur_a : 8'($urandom);
    bus.cmd_b      = want_cmd ? cur_b : 8'($urandom);
    bus.write_rdy  = fast || ($urandom_range(0, 3) != 0);
    if (hold_w > 0 && bus.write_en) begin
      bus.write_rdy = 1'b0; hold_w--; n_wstall++;
      check("wstall_addr", {29'd0, bus.write_address}, 32'd4);
      check("wstall_data", {24'd0, bus.write_data}, {24'd0, cur_a});
    end
    bus.read_rdy   = fast || ($urandom_range(0, 3) != 0);
    bus.res_ready  = fast || ($urandom_range(0, 2) != 0);
    if (hold_r > 0 && bus.res_valid) begin
      bus.res_ready = 1'b0; hold_r--; n_rstall++;
    end
    bus.read_data  = status_of(bus.read_address);
    #1;
    cyc++;
    if (RST) begin
      check("rst_outs", {5'd0, bus.cmd_ready, bus.res_valid, bus.res_data, bus.res_err,
                         bus.write_address, bus.write_data, bus.write_en,
                         bus.read_address, bus.read_en}, 32'd0);
    end else begin
      check("onehot", 32'($countones({bus.cmd_ready, bus.res_valid, bus.write_en, bus.read_en}) <= 1), 32'd1);
      if (bus.write_en) begin
        check("wr_addr", 32'(bus.write_address == 3'd4 || bus.write_address == 3'd5), 32'd1);
        check("wr_data", {24'd0, bus.write_data}, {24'd0, (bus.write_address == 3'd4) ? cur_a : cur_b});
      end else begin
        check("wr_idle", {21'd0, bus.write_address, bus.write_data}, 32'd0);
      end
      if (!bus.read_en) check("rd_idle", {29'd0, bus.read_address}, 32'd0);
      if (bus.res_valid) begin
        check("res_data", {24'd0, bus.res_data}, {24'd0, exp_res});
        check("res_err", {31'd0, bus.res_err}, {31'd0, exp_err});
      end
      if (bus.write_en && bus.write_rdy) begin
        if (bus.write_address == 3'd4) begin nwr_a++; wa = bus.write_data; end
        if (bus.write_address == 3'd5) begin nwr_b++; wb = bus.write_data; end
      end
      if (bus.read_en && bus.read_rdy) begin
        nrd[bus.read_address]++;
        pend_rd = int'(bus.read_address);
      end
      if (want_cmd && bus.cmd_ready) begin want_cmd = 1'b0; acc_cyc = cyc; end
    end
  endtask

  // Expected outcome from the status scripts: the first phase whose
  // not-ready run reaches LIM times out and suppresses everything after it.
  task automatic prep(input logic [7:0] a, input logic [7:0] b);
    int n [3];
    int t;
    cur_a = a; cur_b = b;
    for (int p = 0; p < 3; p++) begin ptr[p] = 0; n[p] = not_ready_count(p); end
    for (int i = 0; i < 8; i++) nrd[i] = 0;
    nwr_a = 0; nwr_b = 0; wa = 8'h00; wb = 8'h00; pend_rd = -1;
    t = -1;
    for (int p = 0; p < 3; p++) if (t < 0 && n[p] >= LIM) t = p;
    for (int p = 0; p < 3; p++)
      exp_rd[p] = (t < 0 || p < t) ? n[p] + 1 : ((p == t) ? LIM : 0);
    exp_rd[3] = (t < 0) ? 1 : 0;
    exp_wa    = (t < 0 || t > 0) ? 1 : 0;
    exp_wb    = (t < 0 || t > 1) ? 1 : 0;
    exp_res   = (t < 0) ? (a | b) : 8'h00;
    exp_err   = (t >= 0);
  endtask

  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input bit chk_lat);
    bit done, seen;
    int lat, budget;
    prep(a, b);
    want_cmd = 1'b1;
    done = 0; seen = 0; lat = -1; budget = 0;
    while (!done && budget < 500) begin
      step();
      budget++;
      if (bus.res_valid && !seen) begin seen = 1; lat = cyc - acc_cyc; end
      if (bus.res_valid && bus.res_ready) done = 1;
    end
    check("handshake", {31'd0, done}, 32'd1);
    if (chk_lat) check("latency", 32'(lat), 32'd7);
    check("rd_a_polls", 32'(nrd[0]), 32'(exp_rd[0]));
    check("rd_b_polls", 32'(nrd[1]), 32'(exp_rd[1]));
    check("rd_y_polls", 32'(nrd[2]), 32'(exp_rd[2]));
    check("rd_result", 32'(nrd[3]), 32'(exp_rd[3]));
    check("wr_a_count", 32'(nwr_a), 32'(exp_wa));
    check("wr_b_count", 32'(nwr_b), 32'(exp_wb));
    step();
    check("ready_after", {31'd0, bus.cmd_ready}, 32'd1);
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_a = 8'h00; bus.cmd_b = 8'h00;
    bus.res_ready = 1'b0; bus.write_rdy = 1'b0; bus.read_rdy = 1'b0;
    bus.read_data = 8'h00;
    RST = 1'b1; rst_drive = 1'b1; fast = 1'b1; want_cmd = 1'b0;
    hold_w = 0; hold_r = 0; n_wstall = 0; n_rstall = 0; cyc = 0; acc_cyc = 0;
    pend_rd = -1;
    for (int p = 0; p < 3; p++) begin ptr[p] = 0; fill(p, 0); end
    repeat (3) step();
    rst_drive = 1'b0;
    step();
    check("reset_ready", {31'd0, bus.cmd_ready}, 32'd1);

    // Directed OR with three not-ready result polls.
    fill(0, 0); fill(1, 0);
    seq[2].delete(); push_n(2, 8'h00, 3); push_n(2, 8'h01, 1);
    run_txn(8'h0F, 8'hF0, 1'b0);

    // No stalls, all status ready.
    fill(0, 0); fill(1, 0); fill(2, 0);
    run_txn(8'h35, 8'h42, 1'b1);

    // Write backpressure in WR_A.
    fill(0, 0); fill(1, 0); fill(2, 0);
    hold_w = 5; n_wstall = 0;
    run_txn(8'hA5, 8'h0C, 1'b0);
    check("wstall_cycles", 32'(n_wstall), 32'd5);

    // Result never available.
    fill(0, 0); fill(1, 0);
    seq[2].delete(); push_n(2, 8'h00, LIM + 2);
    run_txn(8'h11, 8'h22, 1'b0);

    // Response stall, then a back-to-back command.
    fill(0, 0); fill(1, 0); fill(2, 0);
    hold_r = 4; n_rstall = 0;
    run_txn(8'h80, 8'h01, 1'b0);
    check("rstall_cycles", 32'(n_rstall), 32'd4);
    fill(0, 0); fill(1, 0); fill(2, 0);
    run_txn(8'h5A, 8'hA0, 1'b0);

    // Only bit 0 of status matters.
    seq[0].delete(); push_n(0, 8'hFE, 1); push_n(0, 8'h01, 1);
    fill(1, 0); fill(2, 0);
    run_txn(8'h03, 8'h30, 1'b0);

    // Reset pulsed during result polling.
    fill(0, 0); fill(1, 0);
    seq[2].delete(); push_n(2, 8'h00, LIM + 2);
    prep(8'h77, 8'h88);
    want_cmd = 1'b1;
    begin
      int budget;
      budget = 0;
      while (!(bus.read_en && bus.read_address == 3'd2) && budget < 100) begin
        step(); budget++;
      end
      check("reach_poll_y", 32'(bus.read_en && bus.read_address == 3'd2), 32'd1);
    end
    rst_drive = 1'b1;
    step();
    check("midrst_rd_en", {31'd0, bus.read_en}, 32'd0);
    check("midrst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    rst_drive = 1'b0;
    step();
    check("midrst_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("midrst_no_rd3", 32'(nrd[3]), 32'd0);
    want_cmd = 1'b0;
    fill(0, 0); fill(1, 0); fill(2, 1);
    run_txn(8'h19, 8'h64, 1'b0);

    // Randomized commands, status runs and handshake timing.
    fast = 1'b0;
    repeat (30) begin
      for (int p = 0; p < 3; p++)
        fill(p, ($urandom_range(0, 3) == 0) ? $urandom_range(0, LIM + 1) : $urandom_range(0, 3));
      run_txn(8'($urandom), 8'($urandom), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
